fifo_egress_reader: RTL and testbench

//  Drains the four per-destination output FIFOs written by the routing arbiter and merges them onto one

---
 rtl/router_pkg.sv | 10 +
 rtl/egress_skid_fifo.sv | 48 ++++
 rtl/fifo_egress_reader.sv | 131 +++++++++++++
 tb/tb_fifo_egress_reader.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Constants and types shared by the routing arbiter, the egress reader and their benches.
// Word layout: bits [DEST_MSB:DEST_LSB] carry the destination port index.
package router_pkg;
  localparam int W        = 10;
  localparam int NPORT    = 4;
  localparam int DEST_MSB = W - 1;
  localparam int DEST_LSB = W - 2;

  typedef logic [1:0] port_idx_t;
endpackage

// File: rtl/egress_skid_fifo.sv
// DEPTH-entry synchronous FIFO; enq visible at head the next cycle, enq and deq may share a cycle.
// No internal flow control: the caller never enqueues when full nor dequeues when empty.
module egress_skid_fifo #(
  parameter  int DW    = 12,
  parameter  int DEPTH = 2,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enq_i,
  input  logic [DW-1:0] enq_dat_i,
  input  logic          deq_i,
  output logic [CW-1:0] count_o,
  output logic [DW-1:0] head_o
);
  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    rd_d  = deq_i ? ptr_inc(rd_q) : rd_q;
    wr_d  = enq_i ? ptr_inc(wr_q) : wr_q;
    cnt_d = cnt_q + CW'(enq_i) - CW'(deq_i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (enq_i) mem_q[wr_q] <= enq_dat_i;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_q];
endmodule

// File: rtl/fifo_egress_reader.sv
// Round-robin drain of four output FIFOs onto one valid/ready stream; pop at N, out_valid at N+2.
// Credits bound popped-but-undelivered words to BUF_DEPTH, so out_ready low never drops data. Option: EGRESS_CNT_EN.
module fifo_egress_reader
  import router_pkg::*;
#(
  parameter int BUF_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NPORT-1:0]   empty,
  input  logic [NPORT*W-1:0] fifo_data,
  output logic [NPORT-1:0]   pop,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [W-1:0]       out_data,
  output port_idx_t          out_src,
  output logic               route_err
`ifdef EGRESS_CNT_EN
  ,
  input  port_idx_t          cnt_sel,
  input  logic               cnt_clr,
  output logic [15:0]        cnt_val
`endif
);
  localparam int CW = $clog2(BUF_DEPTH + 1);

  typedef struct packed {
    port_idx_t    src;
    logic [W-1:0] word;
  } ent_t;

  logic [NPORT-1:0] pop_q, pop_d;
  logic [NPORT-1:0] cap_q;
  port_idx_t        rr_q, rr_d;
  port_idx_t        grant, idx, cap_src;
  logic             grant_vld, grant_ok;
  logic [CW-1:0]    used_q, used_d, used_ad;
  logic             err_q, err_d;
  logic             enq, deq;
  logic [CW-1:0]    buf_cnt;
  ent_t             cap_ent, head;

  assign deq = out_valid & out_ready;

  // First eligible FIFO at or after rr_q; a FIFO popped this cycle may show a stale empty flag.
  always_comb begin
    grant_vld = 1'b0;
    grant     = rr_q;
    idx       = '0;
    for (int k = NPORT - 1; k >= 0; k--) begin
      idx = rr_q + port_idx_t'(k);
      if (!empty[idx] && !pop_q[idx]) begin
        grant_vld = 1'b1;
        grant     = idx;
      end
    end
    used_ad  = used_q - CW'(deq);
    grant_ok = grant_vld && (used_ad < CW'(BUF_DEPTH));
    pop_d    = '0;
    rr_d     = rr_q;
    if (grant_ok) begin
      pop_d[grant] = 1'b1;
      rr_d         = grant + port_idx_t'(1);
    end
    used_d = used_ad + CW'(grant_ok);
  end

  always_comb begin
    cap_src = '0;
    for (int i = 0; i < NPORT; i++) begin
      if (cap_q[i]) cap_src = port_idx_t'(i);
    end
    enq          = |cap_q;
    cap_ent.src  = cap_src;
    cap_ent.word = fifo_data[int'(cap_src)*W +: W];
    err_d        = err_q | (enq && (cap_ent.word[DEST_MSB:DEST_LSB] != cap_src));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pop_q  <= '0;
      cap_q  <= '0;
      rr_q   <= '0;
      used_q <= '0;
      err_q  <= 1'b0;
    end else begin
      pop_q  <= pop_d;
      cap_q  <= pop_q;
      rr_q   <= rr_d;
      used_q <= used_d;
      err_q  <= err_d;
    end
  end

  egress_skid_fifo #(
    .DW    ($bits(ent_t)),
    .DEPTH (BUF_DEPTH)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .enq_i     (enq),
    .enq_dat_i (cap_ent),
    .deq_i     (deq),
    .count_o   (buf_cnt),
    .head_o    (head)
  );

  assign pop       = pop_q;
  assign out_valid = (buf_cnt != '0);
  assign out_data  = head.word;
  assign out_src   = head.src;
  assign route_err = err_q;

`ifdef EGRESS_CNT_EN
  logic [15:0] cnt_q [NPORT];
  logic [15:0] cnt_val_q;

  // A clear in the same cycle as a delivery wins.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      for (int i = 0; i < NPORT; i++) cnt_q[i] <= '0;
    end else if (deq) begin
      cnt_q[head.src] <= cnt_q[head.src] + 16'd1;
    end
    if (rst) cnt_val_q <= '0;
    else     cnt_val_q <= cnt_q[cnt_sel];
  end

  assign cnt_val = cnt_val_q;
`endif
endmodule

// File: tb/tb_fifo_egress_reader.sv
// Scoreboard bench: a word-level model of the FIFO bank and egress rules predicts pops and outputs.
module tb_fifo_egress_reader;
  import router_pkg::*;

  localparam int BD = 2;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [NPORT-1:0]   empty = '1;
  logic [NPORT*W-1:0] fifo_data = '0;
  logic [NPORT-1:0]   pop;
  logic               out_ready;
  logic               out_valid;
  logic [W-1:0]       out_data;
  port_idx_t          out_src;
  logic               route_err;
`ifdef EGRESS_CNT_EN
  port_idx_t          cnt_sel = '0;
  logic               cnt_clr = 1'b0;
  logic [15:0]        cnt_val;
`endif

  always #5 clk = ~clk;

  fifo_egress_reader #(.BUF_DEPTH(BD)) dut (
    .clk       (clk),
    .rst       (rst),
    .empty     (empty),
    .fifo_data (fifo_data),
    .pop       (pop),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .route_err (route_err)
`ifdef EGRESS_CNT_EN
    ,
    .cnt_sel   (cnt_sel),
    .cnt_clr   (cnt_clr),
    .cnt_val   (cnt_val)
`endif
  );

  typedef struct {
    logic [W-1:0] word;
    int           src;
    int           vis;
  } exp_t;

  logic [W-1:0] fq [NPORT][$];
  exp_t         sb[$];
  logic [3:0]   pop_exp = '0;
  int           rr_m = 0;
  int           cyc = 0;
  int           err_at = 32'h3fff_ffff;
  int           vectors = 0;
  int           miscompares = 0;
  int           pops_seen[NPORT] = '{0, 0, 0, 0};
  int           delivered = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %0h, expected %0h", name, cyc, act, req);
    end
  endtask

  // Every negedge: check the pop the model predicted, serve it from the FIFO model,
  // check the egress outputs, then predict the pop for the coming edge.
  always @(negedge clk) begin
    logic [W-1:0] w;
    bit           mv, deq_m, g_ok;
    int           used, g, i;
    cyc++;
    chk("pop", 32'(pop), 32'(pop_exp));
    for (int p = 0; p < NPORT; p++) begin
      if (pop_exp[p] && fq[p].size() != 0) begin
        w = fq[p].pop_front();
        fifo_data[p*W +: W] = w;
        sb.push_back('{word: w, src: p, vis: cyc + 2});
        if (w[DEST_MSB:DEST_LSB] != 2'(p) && err_at > cyc + 2) err_at = cyc + 2;
        pops_seen[p]++;
      end
    end
    mv = (sb.size() != 0) && (sb[0].vis <= cyc);
    chk("out_valid", 32'(out_valid), 32'(mv));
    chk("route_err", 32'(route_err), 32'(err_at <= cyc));
    if (mv && out_valid) begin
      chk("out_data", 32'(out_data), 32'(sb[0].word));
      chk("out_src", 32'(out_src), 32'(sb[0].src));
    end
    deq_m = mv && out_ready;
    for (int p = 0; p < NPORT; p++) empty[p] = (fq[p].size() == 0);
    used = sb.size();
    if (rst) begin
      sb.delete();
      pop_exp = '0;
      rr_m    = 0;
      err_at  = 32'h3fff_ffff;
    end else begin
      if (deq_m) begin
        void'(sb.pop_front());
        delivered++;
      end
      g_ok = 1'b0;
      g    = 0;
      if (used - int'(deq_m) < BD) begin
        for (int k = 0; k < NPORT; k++) begin
          i = (rr_m + k) % NPORT;
          if (!g_ok && !empty[i] && !pop_exp[i]) begin
            g_ok = 1'b1;
            g    = i;
          end
        end
      end
      pop_exp = '0;
      if (g_ok) begin
        pop_exp[g] = 1'b1;
        rr_m = (g + 1) % NPORT;
      end
    end
  end

  task automatic push(input int f, input logic [W-1:0] w);
    fq[f].push_back(w);
  endtask

  function automatic logic [W-1:0] mkw(input int dest);
    logic [W-1:0] w;
    w = W'($urandom);
    w[DEST_MSB:DEST_LSB] = 2'(dest);
    return w;
  endfunction

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((sb.size() + fq[0].size() + fq[1].size() + fq[2].size() + fq[3].size()) != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(n < 400), 32'd1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, p0;
    logic [W-1:0] w;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_src", 32'(out_src), 32'd0);

    // single word from FIFO2
    @(posedge clk);
    #1 push(2, 10'h2A5);
    drain("t1_drain");
    do_reset();

    // fairness across FIFOs 0, 1 and 3
    @(posedge clk);
    #1;
    for (int r = 0; r < 3; r++) begin
      push(0, mkw(0));
      push(1, mkw(1));
      push(3, mkw(3));
    end
    d0 = delivered;
    drain("t2_drain");
    chk("t2_count", 32'(delivered - d0), 32'd9);

    // backpressure: only BUF_DEPTH pops while stalled
    @(posedge clk);
    #1 out_ready = 1'b0;
    p0 = pops_seen[1];
    for (int r = 0; r < 4; r++) push(1, mkw(1));
    repeat (12) @(posedge clk);
    chk("t3_stalled_pops", 32'(pops_seen[1] - p0), 32'(BD));
    #1 out_ready = 1'b1;
    drain("t3_drain");
    chk("t3_total_pops", 32'(pops_seen[1] - p0), 32'd4);

    // single busy FIFO
    @(posedge clk);
    #1;
    for (int r = 0; r < 3; r++) push(0, mkw(0));
    drain("t4_drain");

    // misrouted word
    @(posedge clk);
    #1 push(3, 10'h0FF);
    drain("t5_drain");
    repeat (3) @(negedge clk);
    chk("t5_sticky", 32'(route_err), 32'd1);

    // reset with two words buffered
    @(posedge clk);
    #1 out_ready = 1'b0;
    push(0, mkw(0));
    push(2, mkw(2));
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("t6_out_data", 32'(out_data), 32'd0);
    chk("t6_out_src", 32'(out_src), 32'd0);
    chk("t6_out_valid", 32'(out_valid), 32'd0);
    chk("t6_route_err", 32'(route_err), 32'd0);
`ifdef EGRESS_CNT_EN
    for (int s = 0; s < NPORT; s++) begin
      @(posedge clk);
      #1 cnt_sel = 2'(s);
      @(posedge clk);
      @(negedge clk);
      chk("t6_cnt_val", 32'(cnt_val), 32'd0);
    end
`endif

    // randomized traffic with random backpressure
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk);
      #1 out_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 2) == 0) begin
        p0 = $urandom_range(0, 3);
        w  = mkw(p0);
        if ($urandom_range(0, 15) == 0) w[DEST_MSB:DEST_LSB] = ~w[DEST_MSB:DEST_LSB];
        push(p0, w);
      end
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    drain("rand_drain");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
